spi_ram_ctrl: RTL

//  Command controller between the SPI slave receive/transmit interface and one single-port RAM.

---
 rtl/spi_ram_pkg.sv | 17 +
 rtl/spi_cmd_capture.sv | 63 ++++++
 rtl/spi_ram_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM state definitions for the SPI-to-RAM command controller.
package spi_ram_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPI_ACC  = 3'd1,
      ST_SPI_RDW  = 3'd2,
      ST_HOST_ACC = 3'd3,
      ST_HOST_RDW = 3'd4
   } state_e;

endpackage

// File: rtl/spi_cmd_capture.sv
// Qualifies rx_valid, captures each SPI frame once per pulse and holds the pending RAM command.
module spi_cmd_capture
   import spi_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RX_WIDTH   = DATA_WIDTH + 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid_i,
   input  logic [RX_WIDTH-1:0]   rx_data_i,
   input  logic                  clr_i,
   output logic                  cap_valid_c,
   output logic [1:0]            cap_op_c,
   output logic [DATA_WIDTH-1:0] cap_data_c,
   output logic                  pend_o,
   output logic [1:0]            pend_op_o,
   output logic [DATA_WIDTH-1:0] pend_data_o
);

   logic                  rx_seen_q;
   logic                  done_q;
   logic                  pend_q;
   logic [1:0]            pend_op_q;
   logic [DATA_WIDTH-1:0] pend_data_q;
   logic                  cap_acc_c;

   // Capture on the second consecutive high cycle, once per pulse.
   assign cap_valid_c = rx_valid_i && rx_seen_q && !done_q;
   assign cap_op_c    = rx_data_i[RX_WIDTH-1 -: 2];
   assign cap_data_c  = rx_data_i[DATA_WIDTH-1:0];
   assign cap_acc_c   = cap_valid_c && ((cap_op_c == CMD_WR_DATA) || (cap_op_c == CMD_RD_DATA));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_seen_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         rx_seen_q <= rx_valid_i;
         done_q    <= rx_valid_i && (done_q || cap_valid_c);
      end
   end

   // A newer RAM command overwrites an unserved one; clear only applies otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         pend_op_q   <= 2'b00;
         pend_data_q <= '0;
      end else if (cap_acc_c) begin
         pend_q      <= 1'b1;
         pend_op_q   <= cap_op_c;
         pend_data_q <= cap_data_c;
      end else if (clr_i) begin
         pend_q      <= 1'b0;
      end
   end

   assign pend_o      = pend_q;
   assign pend_op_o   = pend_op_q;
   assign pend_data_o = pend_data_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command controller sharing one single-port RAM with a host port; SPI has fixed priority.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned ADDR_SIZE  = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RX_WIDTH   = DATA_WIDTH + 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [RX_WIDTH-1:0]   rx_data,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_SIZE-1:0]  host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_e                state_q, state_d;
   logic [ADDR_SIZE-1:0]  wr_addr_q, rd_addr_q;
   logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d, host_gnt_q, host_gnt_d;
   logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  tx_valid_q, host_rvalid_q;
   logic [DATA_WIDTH-1:0] tx_data_q, host_rdata_q;

   logic                  cap_valid_c, pend, pend_clr_c;
   logic [1:0]            cap_op_c, pend_op;
   logic [DATA_WIDTH-1:0] cap_data_c, pend_data;
   logic                  spi_fresh_c, spi_req_c;
   logic [1:0]            spi_op_c;
   logic [DATA_WIDTH-1:0] spi_data_c;

   function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
      return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
   endfunction

   spi_cmd_capture #(.DATA_WIDTH(DATA_WIDTH), .RX_WIDTH(RX_WIDTH)) u_capture (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_valid_i  (rx_valid),
      .rx_data_i   (rx_data),
      .clr_i       (pend_clr_c),
      .cap_valid_c (cap_valid_c),
      .cap_op_c    (cap_op_c),
      .cap_data_c  (cap_data_c),
      .pend_o      (pend),
      .pend_op_o   (pend_op),
      .pend_data_o (pend_data)
   );

   // A RAM command captured this cycle is served immediately, ahead of the host.
   assign spi_fresh_c = cap_valid_c && ((cap_op_c == CMD_WR_DATA) || (cap_op_c == CMD_RD_DATA));
   assign spi_req_c   = spi_fresh_c || pend;
   assign spi_op_c    = spi_fresh_c ? cap_op_c : pend_op;
   assign spi_data_c  = spi_fresh_c ? cap_data_c : pend_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         host_gnt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         host_gnt_q  <= host_gnt_d;
      end
   end

   // RAM port outputs are decoded from the next state so they are registered in the access state.
   always_comb begin
      state_d     = state_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      host_gnt_d  = 1'b0;
      pend_clr_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (spi_req_c) begin
               state_d     = ST_SPI_ACC;
               mem_en_d    = 1'b1;
               mem_we_d    = (spi_op_c == CMD_WR_DATA);
               mem_addr_d  = mem_we_d ? wr_addr_q : rd_addr_q;
               mem_wdata_d = spi_data_c;
            end else if (host_req && !cap_valid_c) begin
               state_d     = ST_HOST_ACC;
               mem_en_d    = 1'b1;
               mem_we_d    = host_we;
               mem_addr_d  = host_addr;
               mem_wdata_d = host_wdata;
               host_gnt_d  = 1'b1;
            end
         end
         ST_SPI_ACC: begin
            pend_clr_c = 1'b1;
            state_d    = mem_we_q ? ST_IDLE : ST_SPI_RDW;
         end
         ST_SPI_RDW:  state_d = ST_IDLE;
         ST_HOST_ACC: state_d = mem_we_q ? ST_IDLE : ST_HOST_RDW;
         ST_HOST_RDW: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Address pointers: a captured address load takes precedence over post-access increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q <= '0;
         rd_addr_q <= '0;
      end else begin
         if (cap_valid_c && (cap_op_c == CMD_WR_ADDR))
            wr_addr_q <= ADDR_SIZE'(cap_data_c);
         else if ((state_q == ST_SPI_ACC) && mem_we_q)
            wr_addr_q <= addr_inc(wr_addr_q);
         if (cap_valid_c && (cap_op_c == CMD_RD_ADDR))
            rd_addr_q <= ADDR_SIZE'(cap_data_c);
         else if ((state_q == ST_SPI_ACC) && !mem_we_q)
            rd_addr_q <= addr_inc(rd_addr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid_q    <= 1'b0;
         tx_data_q     <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         if (state_q == ST_SPI_RDW) begin
            tx_data_q  <= mem_rdata;
            tx_valid_q <= 1'b1;
         end else if (cap_valid_c) begin
            tx_valid_q <= 1'b0;
         end
         host_rvalid_q <= (state_q == ST_HOST_RDW);
         if (state_q == ST_HOST_RDW)
            host_rdata_q <= mem_rdata;
      end
   end

   assign tx_valid    = tx_valid_q;
   assign tx_data     = tx_data_q;
   assign host_gnt    = host_gnt_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;
   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule
